// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back steps and decodes datapath strobes from state.
module mips_multicycle_ctrl #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_MEM_ADDR   = 4'd3,
    S_MEM_READ   = 4'd4,
    S_MEM_WB     = 4'd5,
    S_MEM_WRITE  = 4'd6,
    S_EXECUTE    = 4'd7,
    S_R_COMPLETE = 4'd8,
    S_BRANCH     = 4'd9,
    S_JUMP       = 4'd10,
    S_ADDI_EXEC  = 4'd11,
    S_ADDI_WB    = 4'd12,
    S_TRAP       = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t r_state;
  state_t w_nextState;
  logic   w_memReady;

  // Without handshaking memory every access completes in one cycle.
  assign w_memReady = USE_MEM_READY ? MemReady : 1'b1;
  assign State      = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = S_IDLE;
    case (r_state)
      S_IDLE:       w_nextState = S_FETCH;
      S_FETCH:      w_nextState = w_memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_RTYPE:      w_nextState = S_EXECUTE;
          OP_LW, OP_SW:  w_nextState = S_MEM_ADDR;
          OP_BEQ:        w_nextState = S_BRANCH;
          OP_J:          w_nextState = S_JUMP;
          OP_ADDI:       w_nextState = S_ADDI_EXEC;
          default:       w_nextState = S_TRAP;
        endcase
      end
      // Only lw/sw reach MEM_ADDR, so anything other than lw is a store.
      S_MEM_ADDR:   w_nextState = (Op == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:   w_nextState = w_memReady ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:     w_nextState = S_FETCH;
      S_MEM_WRITE:  w_nextState = w_memReady ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:    w_nextState = S_R_COMPLETE;
      S_R_COMPLETE: w_nextState = S_FETCH;
      S_BRANCH:     w_nextState = S_FETCH;
      S_JUMP:       w_nextState = S_FETCH;
      S_ADDI_EXEC:  w_nextState = S_ADDI_WB;
      S_ADDI_WB:    w_nextState = S_FETCH;
      S_TRAP:       w_nextState = S_FETCH;
      default:      w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    IllegalOp   = 1'b0;
    case (r_state)
      // PC+4 and the IR load only commit on the cycle the fetch completes.
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = w_memReady;
        PCWrite = w_memReady;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_R_COMPLETE: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
      end
      S_TRAP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b11;
        IllegalOp = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode from the instruction register and sequences the datapath through fetch, decode, execute, memory and write-back steps. It produces the 2-bit Select codes (PCSource, ALUSrcB) that drive the datapath's 4:1 selection muxes, plus all enable strobes. It sits upstream of the muxes, register file, ALU control and memory interface.

Parameters:
USE_MEM_READY, 1, 1 = memory states wait for MemReady; 0 = MemReady is ignored and treated as 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
Op  input  6  opcode, IR[31:26]; stable from DECODE until return to FETCH
MemReady  input  1  memory access complete this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU Zero (beq)
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
MemtoReg  output  1  write-back data: 0 = ALUOut, 1 = MDR
RegDst  output  1  destination register: 0 = rt, 1 = rd
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A: 0 = PC, 1 = A register
ALUSrcB  output  2  ALU B mux select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
ALUOp  output  2  00 = add, 01 = sub, 10 = use funct
PCSource  output  2  PC mux select: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector
IllegalOp  output  1  high for the single TRAP cycle
State  output  4  current state, for debug

Behaviour:
- Single clock, clk. Reset is synchronous and active-low (rst_n). It is sampled only on the rising edge of clk.
- State register is 4 bits. Encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_COMPLETE=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, TRAP=13.
- Reset: state becomes IDLE. In IDLE every output is 0 and State=0. After reset releases, IDLE goes to FETCH unconditionally.
- Reset has priority over all transitions, including mid-instruction. No pending strobe survives: the next cycle is IDLE with all outputs 0.
- Outputs are decoded from State. The only exceptions are the MemReady-gated strobes listed below. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by Op:
  - 000000 -> EXECUTE
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> ADDI_EXEC
  - any other Op -> TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Op=lw -> MEM_READ; Op=sw -> MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Hold while MemReady=0, then go to MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1. Then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Hold while MemReady=0, then go to FETCH. MemWrite stays high during the whole wait.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Then R_COMPLETE.
- R_COMPLETE: RegDst=1, MemtoReg=0, RegWrite=1. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Then FETCH.
- JUMP: PCWrite=1, PCSource=10. Then FETCH.
- ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Then ADDI_WB.
- ADDI_WB: RegDst=0, MemtoReg=0, RegWrite=1. Then FETCH.
- TRAP: PCWrite=1, PCSource=11, IllegalOp=1. Then FETCH.
- Cycle counts from FETCH entry, with MemReady=1:
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 3.
  - Each cycle of MemReady=0 in FETCH, MEM_READ or MEM_WRITE adds 1.
- USE_MEM_READY=0: MemReady is internally forced to 1, so no wait cycles occur.
- Unreachable encodings 14 and 15 go to IDLE on the next edge, with all outputs 0.
- No two of MemRead, MemWrite, RegWrite and PCWrite/PCWriteCond are asserted in the same state, except MemRead with PCWrite in FETCH.

Test Plan:
- Hold rst_n=0 for 3 cycles, then release. Required: all outputs 0 and State=0 during reset and for 1 cycle after; State=1 on the next cycle.
- Op=000000, MemReady=1. Required: State 1,2,7,8,1. In State 8: RegWrite=1, RegDst=1, MemtoReg=0. In State 1: IRWrite=1 and PCWrite=1.
- Op=100011; MemReady=0 for 2 cycles in FETCH and 3 cycles in MEM_READ. Required: total 10 cycles; IRWrite asserts only on the ready cycle; State 5 gives RegWrite=1, MemtoReg=1.
- Op=000100, then Op=000010. Required for beq: State 9 with PCWriteCond=1, PCSource=01, ALUOp=01. Required for j: State 10 with PCWrite=1, PCSource=10. Each instruction takes 3 cycles.
- Op=111111. Required: DECODE -> TRAP with IllegalOp=1, PCWrite=1, PCSource=11 for exactly 1 cycle, then FETCH.
- Op=101011 with MemReady=0 held in MEM_WRITE; pull rst_n=0 for 1 cycle. Required: MemWrite drops to 0 and State=0 the next cycle; FETCH follows.
